// File: rtl/spi_xfer_arbiter_pkg.sv
// Shared types and defaults for the SPI transfer arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RX = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    localparam int          DATA_W_DEF  = 32;
    localparam logic [15:0] TMO_CYC_DEF = 16'hFFFF;

endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// Requester-side and controller-side handshake bundle of the SPI transfer arbiter.
interface spi_xfer_arbiter_if
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         spi_tx_data;
    logic                      spi_tx_valid;
    logic                      spi_tx_ready;
    logic [DATA_W-1:0]         spi_rx_data;
    logic                      spi_rx_valid;
    logic                      spi_rx_ready;
    logic                      spi_busy;

    // The arbiter is the master of this bundle.
    modport master (
        input  req_valid, req_data, rsp_ready,
        input  spi_tx_ready, spi_rx_data, spi_rx_valid, spi_busy,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output spi_tx_data, spi_tx_valid, spi_rx_ready
    );

    modport slave (
        output req_valid, req_data, rsp_ready,
        output spi_tx_ready, spi_rx_data, spi_rx_valid, spi_busy,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  spi_tx_data, spi_tx_valid, spi_rx_ready
    );

endinterface

// File: rtl/spi_xfer_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = IDX_W'((int'(ptr) + i) % N);
            if (en && !any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Round-robin sharing of one SPI controller transaction port among NUM_REQ requesters,
// with a per-transfer rx timeout and a saturating timeout event counter.
module spi_xfer_arbiter
    import spi_arb_pkg::*;
#(
    parameter int               NUM_REQ = 4,
    parameter int               DATA_W  = DATA_W_DEF,
    parameter int               TMO_W   = 16,
    parameter logic [TMO_W-1:0] TMO_CYC = TMO_W'(TMO_CYC_DEF)
) (
    input  logic                       core_clk,
    input  logic                       arst_n,
    spi_xfer_arbiter_if.master         bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [7:0]                 tmo_count
);

    localparam int IDX_W = $clog2(NUM_REQ);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
        return (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + IDX_W'(1);
    endfunction

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] g);
        return NUM_REQ'(1) << g;
    endfunction

    arb_state_t       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_cnt_inc;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic               arb_en;

    // Accept is combinational so the word is latched in the same cycle req_ready is seen.
    assign arb_en      = (state == IDLE) && !bus.spi_busy && arst_n;
    assign tmo_cnt_inc = tmo_cnt + TMO_W'(1);
    assign bus.req_ready = gnt;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            tmo_cnt          <= '0;
            grant_id         <= '0;
            tmo_count        <= '0;
            bus.spi_tx_data  <= '0;
            bus.spi_tx_valid <= 1'b0;
            bus.spi_rx_ready <= 1'b0;
            bus.rsp_valid    <= '0;
            bus.rsp_data     <= '0;
            bus.rsp_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        bus.spi_tx_data  <= bus.req_data[gnt_idx*DATA_W +: DATA_W];
                        bus.spi_tx_valid <= 1'b1;
                        grant_id         <= gnt_idx;
                        rr_ptr           <= next_ptr(gnt_idx);
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.spi_tx_ready) begin
                        bus.spi_tx_valid <= 1'b0;
                        bus.spi_rx_ready <= 1'b1;
                        tmo_cnt          <= '0;
                        state            <= WAIT_RX;
                    end
                end
                WAIT_RX: begin
                    // A word arriving on the timeout cycle still wins.
                    if (bus.spi_rx_valid) begin
                        bus.rsp_data     <= bus.spi_rx_data;
                        bus.rsp_err      <= 1'b0;
                        bus.spi_rx_ready <= 1'b0;
                        bus.rsp_valid    <= to_onehot(grant_id);
                        state            <= RESP;
                    end else if (tmo_cnt_inc == TMO_CYC) begin
                        bus.rsp_data     <= '0;
                        bus.rsp_err      <= 1'b1;
                        tmo_count        <= sat_inc8(tmo_count);
                        bus.spi_rx_ready <= 1'b0;
                        bus.rsp_valid    <= to_onehot(grant_id);
                        state            <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt_inc;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[grant_id]) begin
                        bus.rsp_valid <= '0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Randomized bench for spi_xfer_arbiter: the bench plays requesters and SPI controller
// and checks every transfer against a transaction-level round-robin/timeout model.
module tb_spi_xfer_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int TMO  = 16;

    logic       core_clk = 1'b0;
    logic       arst_n   = 1'b0;
    logic [1:0] grant_id;
    logic [7:0] tmo_count;

    spi_xfer_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(DW)) bus ();

    spi_xfer_arbiter #(
        .NUM_REQ (NREQ),
        .DATA_W  (DW),
        .TMO_W   (16),
        .TMO_CYC (16'(TMO))
    ) dut (
        .core_clk  (core_clk),
        .arst_n    (arst_n),
        .bus       (bus),
        .grant_id  (grant_id),
        .tmo_count (tmo_count)
    );

    always #5 core_clk = ~core_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_ptr    = 0;
    int          m_tmo    = 0;
    logic [31:0] words [NREQ];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] m, input int p);
        for (int i = 0; i < NREQ; i++)
            if (m[(p + i) % NREQ]) return (p + i) % NREQ;
        return 0;
    endfunction

    // Starts and ends shortly after a falling edge with the DUT idle.
    task automatic run_xfer(input logic [3:0] mask, input int busy_cyc, input int tx_wait,
                            input int rx_dly, input int rsp_wait, input logic [31:0] rx_base,
                            input logic force_tx, input logic [31:0] tx_force);
        int          g;
        int          lim;
        logic [3:0]  oh;
        logic [31:0] rxw;
        logic [31:0] exp_data;
        logic        exp_err;
        g  = pick(mask, m_ptr);
        oh = 4'b0001 << g;
        for (int i = 0; i < NREQ; i++) begin
            words[i] = $urandom;
            if (force_tx && i == g) words[i] = tx_force;
            bus.req_data[i*DW +: DW] = words[i];
        end
        bus.req_valid = mask;
        bus.spi_busy  = (busy_cyc > 0);
        for (int k = 0; k < busy_cyc; k++) begin
            #1 check_val("busy_no_ready", 64'(bus.req_ready), 64'd0);
            @(negedge core_clk);
        end
        bus.spi_busy = 1'b0;
        #1 check_val("grant_ready", 64'(bus.req_ready), 64'(oh));
        @(negedge core_clk);
        m_ptr = (g + 1) % NREQ;
        if ($urandom_range(1, 0) == 1) bus.req_valid = '0;
        #1 check_val("ready_pulse", 64'(bus.req_ready), 64'd0);
        check_val("grant_id", 64'(grant_id), 64'(g));
        for (int k = 0; k < tx_wait; k++) begin
            bus.spi_tx_ready = 1'b0;
            bus.spi_rx_valid = 1'($urandom_range(1, 0));
            bus.spi_rx_data  = $urandom;
            #1 check_val("tx_valid_hold", 64'(bus.spi_tx_valid), 64'd1);
            check_val("tx_data_hold", 64'(bus.spi_tx_data), 64'(words[g]));
            check_val("issue_rx_ready", 64'(bus.spi_rx_ready), 64'd0);
            @(negedge core_clk);
        end
        bus.spi_rx_valid = 1'b0;
        bus.spi_tx_ready = 1'b1;
        #1 check_val("tx_valid", 64'(bus.spi_tx_valid), 64'd1);
        check_val("tx_data", 64'(bus.spi_tx_data), 64'(words[g]));
        @(negedge core_clk);
        bus.spi_tx_ready = 1'b0;
        bus.req_valid    = '0;
        lim = (rx_dly < TMO) ? rx_dly : TMO - 1;
        rxw = rx_base ^ 32'(g);
        for (int k = 0; k <= lim; k++) begin
            #1 check_val("wait_rx_ready", 64'(bus.spi_rx_ready), 64'd1);
            check_val("wait_no_rsp", 64'(bus.rsp_valid), 64'd0);
            check_val("wait_tx_idle", 64'(bus.spi_tx_valid), 64'd0);
            if (k == rx_dly) begin
                bus.spi_rx_valid = 1'b1;
                bus.spi_rx_data  = rxw;
            end
            @(negedge core_clk);
        end
        bus.spi_rx_valid = 1'b0;
        bus.spi_rx_data  = $urandom;
        if (rx_dly >= TMO) begin
            exp_data = '0;
            exp_err  = 1'b1;
            m_tmo    = (m_tmo < 255) ? m_tmo + 1 : 255;
        end else begin
            exp_data = rxw;
            exp_err  = 1'b0;
        end
        for (int k = 0; k <= rsp_wait; k++) begin
            if (k == rsp_wait) bus.rsp_ready = oh | 4'($urandom);
            else               bus.rsp_ready = 4'($urandom) & ~oh;
            bus.spi_rx_valid = 1'($urandom_range(1, 0));
            #1 check_val("rsp_valid", 64'(bus.rsp_valid), 64'(oh));
            check_val("rsp_data", 64'(bus.rsp_data), 64'(exp_data));
            check_val("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
            check_val("tmo_count", 64'(tmo_count), 64'(m_tmo));
            check_val("resp_rx_ready", 64'(bus.spi_rx_ready), 64'd0);
            @(negedge core_clk);
        end
        bus.rsp_ready    = '0;
        bus.spi_rx_valid = 1'b0;
        #1 check_val("rsp_done", 64'(bus.rsp_valid), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_tx_valid"}, 64'(bus.spi_tx_valid), 64'd0);
        check_val({tag, "_tx_data"}, 64'(bus.spi_tx_data), 64'd0);
        check_val({tag, "_rx_ready"}, 64'(bus.spi_rx_ready), 64'd0);
        check_val({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        check_val({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'd0);
        check_val({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'd0);
        check_val({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        check_val({tag, "_grant_id"}, 64'(grant_id), 64'd0);
        check_val({tag, "_tmo_count"}, 64'(tmo_count), 64'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int dly;
        bus.req_valid    = 4'hF;
        bus.req_data     = '0;
        bus.rsp_ready    = '0;
        bus.spi_tx_ready = 1'b0;
        bus.spi_rx_data  = '0;
        bus.spi_rx_valid = 1'b0;
        bus.spi_busy     = 1'b0;
        repeat (3) @(negedge core_clk);
        #1 check_all_zero("reset");
        bus.req_valid = '0;
        @(negedge core_clk);
        arst_n = 1'b1;
        @(negedge core_clk);

        // Fairness: all requesters valid, rx one cycle after tx accept.
        for (int i = 0; i < 8; i++)
            run_xfer(4'hF, 0, 0, 0, 0, 32'hA5A5_0000, 1'b0, 32'h0);

        // Stalled tx accept, timeout, rx on the timeout cycle, busy hold-off.
        run_xfer(4'b0100, 0, 5, 0, 1, 32'h1234_0000, 1'b1, 32'hDEAD_BEEF);
        run_xfer(4'($urandom_range(15, 1)), 0, 0, TMO, 0, 32'h0, 1'b0, 32'h0);
        run_xfer(4'($urandom_range(15, 1)), 0, 0, TMO - 1, 0, 32'hC0DE_0000, 1'b0, 32'h0);
        run_xfer(4'b0010, 3, 0, 1, 0, 32'h5555_0000, 1'b0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            dly = ($urandom_range(4, 0) == 0) ? $urandom_range(TMO + 4, TMO - 2)
                                              : $urandom_range(6, 0);
            run_xfer(4'($urandom_range(15, 1)), $urandom_range(2, 0), $urandom_range(3, 0),
                     dly, $urandom_range(3, 0), $urandom, 1'b0, 32'h0);
        end

        // Reset in the middle of WAIT_RX.
        bus.req_valid = 4'b1000;
        @(negedge core_clk);
        bus.req_valid    = '0;
        bus.spi_tx_ready = 1'b1;
        @(negedge core_clk);
        bus.spi_tx_ready = 1'b0;
        @(negedge core_clk);
        #1 check_val("pre_reset_rx_ready", 64'(bus.spi_rx_ready), 64'd1);
        bus.req_valid = 4'hF;
        arst_n = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge core_clk);
        bus.req_valid = '0;
        arst_n = 1'b1;
        m_ptr  = 0;
        m_tmo  = 0;
        @(negedge core_clk);
        run_xfer(4'hF, 0, 0, 2, 0, 32'h7777_0000, 1'b0, 32'h0);

        // Saturation of the timeout event counter.
        for (int i = 0; i < 300; i++)
            run_xfer(4'($urandom_range(15, 1)), 0, 0, TMO, 0, 32'h0, 1'b0, 32'h0);
        check_val("tmo_saturated", 64'(tmo_count), 64'd255);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
- Shares one SPI controller transaction port among NUM_REQ requesters in the core_clk domain.
- Picks a requester round-robin, issues its 32-bit word to the controller's tx handshake, and waits for the controller's rx word.
- Returns that word to the granted requester only, with a timeout guard.
- Sits between bus-side clients (e.g. flash, sensor, debug agents) and the SPI controller.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, transfer word width; must match the controller
- TMO_W, 16, width of the timeout counter
- TMO_CYC, 16'hFFFF, core_clk cycles allowed in WAIT_RX before timeout

Ports:
- core_clk  in  1  processing clock; all logic is on the rising edge
- arst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester transfer request
- req_data  in  NUM_REQ*DATA_W  packed request words; requester i uses bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot request accept
- rsp_valid  out  NUM_REQ  one-hot response valid
- rsp_data  out  DATA_W  response word, shared by all requesters
- rsp_err  out  1  response qualifier: 1 = timeout, data is zero
- rsp_ready  in  NUM_REQ  per-requester response accept
- spi_tx_data  out  DATA_W  word to the controller
- spi_tx_valid  out  1  controller tx request
- spi_tx_ready  in  1  controller tx accept
- spi_rx_data  in  DATA_W  controller rx word
- spi_rx_valid  in  1  controller rx word available
- spi_rx_ready  out  1  rx accept to the controller
- spi_busy  in  1  controller busy status
- grant_id  out  $clog2(NUM_REQ)  index of the current/last grant
- tmo_count  out  8  saturating timeout event counter

Behaviour:
- Reset values, all asynchronous: state=IDLE, all outputs 0, rr pointer=0, grant_id=0, tmo_count=0.
- FSM states: IDLE, ISSUE, WAIT_RX, RESP.
- IDLE:
  - Move to ISSUE only when some req_valid=1 and spi_busy=0.
  - Grant the first asserted requester at or after the rr pointer, wrapping modulo NUM_REQ.
  - In the same cycle: pulse req_ready[g] for exactly 1 cycle, latch req_data[g] into the tx holding register, set grant_id=g.
  - Advance the rr pointer to g+1, wrapping.
  - A request with spi_busy=1 waits; the grant is taken only when spi_busy=0.
- ISSUE:
  - spi_tx_valid=1 with spi_tx_data held stable.
  - Leave when spi_tx_valid && spi_tx_ready; go to WAIT_RX the next cycle.
  - tx_valid never drops before it is accepted.
- WAIT_RX:
  - spi_rx_ready=1, timeout counter increments every cycle.
  - On spi_rx_valid: capture spi_rx_data into rsp_data, set rsp_err=0, go to RESP.
  - If the counter reaches TMO_CYC: set rsp_data=0, rsp_err=1, increment tmo_count (saturates at 8'hFF), go to RESP.
  - If rx_valid and the timeout occur in the same cycle, rx_valid wins.
- RESP:
  - rsp_valid[grant_id]=1; rsp_data and rsp_err are held.
  - Leave on rsp_ready[grant_id]; return to IDLE the next cycle.
  - rsp_ready from non-granted requesters is ignored.
- Latency: minimum request-accept to response is 1 (IDLE) + 1 (ISSUE, if tx_ready is already high) + rx latency + 1 cycle.
- Back-to-back: a new grant is possible in the cycle after RESP completes.
- Fairness: with all requesters valid, grants rotate 0,1,..,NUM_REQ-1,0.
- Mid-operation reset: asynchronous return to reset values. No response is issued; the requester must re-request.
- A requester dropping req_valid after grant has no effect; the transfer completes.
- spi_rx_valid outside WAIT_RX is ignored; spi_rx_ready=0 there.

Decomposition:
- Package spi_arb_pkg:
  - state enum (IDLE=2'd0, ISSUE=2'd1, WAIT_RX=2'd2, RESP=2'd3)
  - DATA_W default
  - default TMO_CYC
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], ptr, en.
  - Outputs: one-hot gnt, gnt_idx, any.
  - Purely combinational priority rotate; the pointer register stays in the parent.

Test Plan:
- All 4 requesters valid continuously, rx returns 1 cycle after tx accept -> grants in order 0,1,2,3,0; each rsp_valid one-hot to the matching requester; rsp_data equals the injected rx word (e.g. 32'hA5A5_0003 for requester 3).
- Requester 2 sends 32'hDEAD_BEEF, tx_ready held low 5 cycles -> spi_tx_valid stays 1 and data stays stable for 5 cycles; accept on cycle 6; WAIT_RX next.
- TMO_CYC=16, no rx_valid -> after 16 WAIT_RX cycles rsp_err=1, rsp_data=0, tmo_count 0->1; 300 timeouts -> tmo_count saturates at 255.
- rx_valid and timeout in the same cycle -> rsp_err=0, rsp_data=rx word, tmo_count unchanged.
- spi_busy=1 with req_valid[1]=1 -> no req_ready; busy drops -> req_ready[1] pulses 1 cycle.
- arst_n asserted in WAIT_RX -> all outputs 0 immediately; after release, a new request is granted from pointer 0.
